// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU-side signal bundle for alu_arbiter (stats under ALU_ARB_STATS_EN)
interface alu_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int STAT_W = 16
);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [WORD_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WORD_W-1:0] rsp0_data, rsp1_data;
  logic [2:0]        rsp0_flags, rsp1_flags;
  logic [OP_W-1:0]   alu_op;
  logic [WORD_W-1:0] alu_porta, alu_portb, alu_out;
  logic              alu_neg, alu_ovf, alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_gnt0, stat_gnt1, stat_busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output alu_op, alu_porta, alu_portb,
    input  alu_out, alu_neg, alu_ovf, alu_zero,
    output stat_gnt0, stat_gnt1, stat_busy
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  alu_op, alu_porta, alu_portb,
    output alu_out, alu_neg, alu_ovf, alu_zero,
    input  stat_gnt0, stat_gnt1, stat_busy
  );
`else
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output alu_op, alu_porta, alu_portb,
    input  alu_out, alu_neg, alu_ovf, alu_zero
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  alu_op, alu_porta, alu_portb,
    output alu_out, alu_neg, alu_ovf, alu_zero
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Optional saturating statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int STAT_W = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  logic              r_last_grant, r_gnt;
  logic [OP_W-1:0]   r_op;
  logic [WORD_W-1:0] r_a, r_b, r_data;
  logic [2:0]        r_flags;

  logic w_win1, w_accept, w_rsp_ready, w_resp;

  // Ready is gated by nRST so an asserted reset shows no ready even with valids held high.
  assign w_win1      = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_accept    = nRST && (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_resp      = (r_state == RESP);
  assign w_rsp_ready = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = w_accept && !w_win1;
  assign bus.req1_ready = w_accept && w_win1;
  assign bus.rsp0_valid = w_resp && !r_gnt;
  assign bus.rsp1_valid = w_resp && r_gnt;
  assign bus.rsp0_data  = r_data;
  assign bus.rsp1_data  = r_data;
  assign bus.rsp0_flags = r_flags;
  assign bus.rsp1_flags = r_flags;
  assign bus.alu_op     = r_op;
  assign bus.alu_porta  = r_a;
  assign bus.alu_portb  = r_b;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
      r_flags      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_gnt        <= w_win1;
          r_last_grant <= w_win1;
          r_op         <= w_win1 ? bus.req1_op : bus.req0_op;
          r_a          <= w_win1 ? bus.req1_a  : bus.req0_a;
          r_b          <= w_win1 ? bus.req1_b  : bus.req0_b;
          r_state      <= EXEC;
        end
        EXEC: begin
          r_data  <= bus.alu_out;
          r_flags <= {bus.alu_neg, bus.alu_ovf, bus.alu_zero};
          r_state <= RESP;
        end
        RESP: if (w_rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_gnt0, r_stat_gnt1, r_stat_busy;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_gnt0 <= '0;
      r_stat_gnt1 <= '0;
      r_stat_busy <= '0;
    end else begin
      if (bus.req0_ready && r_stat_gnt0 != '1) r_stat_gnt0 <= r_stat_gnt0 + STAT_W'(1);
      if (bus.req1_ready && r_stat_gnt1 != '1) r_stat_gnt1 <= r_stat_gnt1 + STAT_W'(1);
      if (r_state != IDLE && r_stat_busy != '1) r_stat_busy <= r_stat_busy + STAT_W'(1);
    end
  end

  assign bus.stat_gnt0 = r_stat_gnt0;
  assign bus.stat_gnt1 = r_stat_gnt1;
  assign bus.stat_busy = r_stat_busy;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a small reference ALU
module tb_alu_arbiter;
`ifdef ALU_ARB_STATS_EN
  localparam int STAT_W = 2;
`else
  localparam int STAT_W = 16;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  alu_arbiter_if #(.WORD_W(32), .OP_W(4), .STAT_W(STAT_W)) bus ();
  alu_arbiter #(.WORD_W(32), .OP_W(4), .STAT_W(STAT_W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  // Reference ALU: 2 = ADD, 3 = SUB, anything else = AND.
  logic [31:0] m_res;
  logic        m_ovf;
  always_comb begin
    m_res = bus.alu_porta & bus.alu_portb;
    m_ovf = 1'b0;
    case (bus.alu_op)
      4'h2: begin
        m_res = bus.alu_porta + bus.alu_portb;
        m_ovf = (bus.alu_porta[31] == bus.alu_portb[31]) && (m_res[31] != bus.alu_porta[31]);
      end
      4'h3: begin
        m_res = bus.alu_porta - bus.alu_portb;
        m_ovf = (bus.alu_porta[31] != bus.alu_portb[31]) && (m_res[31] != bus.alu_porta[31]);
      end
      default: ;
    endcase
  end
  assign bus.alu_out  = m_res;
  assign bus.alu_neg  = m_res[31];
  assign bus.alu_ovf  = m_ovf;
  assign bus.alu_zero = (m_res == 32'h0);

  int vectors = 0;
  int miscompares = 0;

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b expected 0000",
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    vectors++;
    if ({bus.alu_op, bus.alu_porta, bus.alu_portb, bus.rsp0_data, bus.rsp0_flags} !== '0) begin
      miscompares++;
      $display("FAIL reset_alu: got op=%h a=%h b=%h expected zeros", bus.alu_op, bus.alu_porta, bus.alu_portb);
    end
    clear_inputs();
    nRST = 1'b1;
  endtask

  task automatic test_add();
    @(negedge CLK);
    bus.req0_valid = 1; bus.req0_op = 4'h2; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL add_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge CLK);
    bus.req0_valid = 0;
    #1;
    vectors++;
    if ({bus.rsp0_valid, bus.req0_ready, bus.alu_op, bus.alu_porta, bus.alu_portb} !== {2'b00, 4'h2, 32'd5, 32'd7}) begin
      miscompares++;
      $display("FAIL add_exec: got valid=%b op=%h a=%h b=%h expected 0 2 5 7",
               bus.rsp0_valid, bus.alu_op, bus.alu_porta, bus.alu_portb);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp0_flags} !== {2'b10, 32'h0000000C, 3'b000}) begin
      miscompares++;
      $display("FAIL add_rsp: got valid=%b data=%h flags=%b expected 1 0000000c 000",
               bus.rsp0_valid, bus.rsp0_data, bus.rsp0_flags);
    end
    bus.rsp0_ready = 1;
    @(negedge CLK);
    bus.rsp0_ready = 0;
    #1;
    vectors++;
    if (bus.rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_rsp_done: got %b expected 0", bus.rsp0_valid);
    end
  endtask

  task automatic test_both();
    @(negedge CLK);
    nRST = 0; #1; nRST = 1;
    bus.req0_valid = 1; bus.req0_op = 4'h3; bus.req0_a = 32'd3; bus.req0_b = 32'd3;
    bus.req1_valid = 1; bus.req1_op = 4'h2; bus.req1_a = 32'h7FFFFFFF; bus.req1_b = 32'd1;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL both_first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge CLK);
    bus.req0_valid = 0;
    #1;
    vectors++;
    if (bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL both_busy_ready: got %b expected 0", bus.req1_ready);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp0_flags} !== {2'b10, 32'h0, 3'b001}) begin
      miscompares++;
      $display("FAIL both_rsp0: got valid=%b%b data=%h flags=%b expected 10 00000000 001",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp0_flags);
    end
    bus.rsp0_ready = 1;
    @(negedge CLK);
    bus.rsp0_ready = 0;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL both_second_grant: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge CLK);
    bus.req1_valid = 0;
    @(negedge CLK); #1;
    vectors++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_flags} !== {2'b01, 32'h80000000, 3'b110}) begin
      miscompares++;
      $display("FAIL both_rsp1: got valid=%b%b data=%h flags=%b expected 01 80000000 110",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_flags);
    end
    bus.rsp1_ready = 1;
    @(negedge CLK);
    bus.rsp1_ready = 0;
  endtask

  task automatic test_stall();
    @(negedge CLK);
    bus.req0_valid = 1; bus.req0_op = 4'h0; bus.req0_a = 32'h0000F0F0; bus.req0_b = 32'h0000FF00;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_accept0: got %b expected 1", bus.req0_ready);
    end
    @(negedge CLK);
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_op = 4'h2; bus.req1_a = 32'd1; bus.req1_b = 32'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); #1;
      vectors++;
      if ({bus.rsp0_valid, bus.req1_ready, bus.rsp0_data, bus.rsp0_flags} !== {2'b10, 32'h0000F000, 3'b000}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b r1rdy=%b data=%h flags=%b expected 1 0 0000f000 000",
                 i, bus.rsp0_valid, bus.req1_ready, bus.rsp0_data, bus.rsp0_flags);
      end
    end
    bus.rsp0_ready = 1;
    @(negedge CLK);
    bus.rsp0_ready = 0;
    #1;
    vectors++;
    if (bus.req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_accept1: got %b expected 1", bus.req1_ready);
    end
    @(negedge CLK);
    bus.req1_valid = 0;
    @(negedge CLK); #1;
    vectors++;
    if ({bus.rsp1_valid, bus.rsp1_data} !== {1'b1, 32'd3}) begin
      miscompares++;
      $display("FAIL stall_rsp1: got valid=%b data=%h expected 1 00000003", bus.rsp1_valid, bus.rsp1_data);
    end
    bus.rsp1_ready = 1;
    @(negedge CLK);
    bus.rsp1_ready = 0;
  endtask

  task automatic test_reset_exec();
    @(negedge CLK);
    bus.req1_valid = 1; bus.req1_op = 4'h2; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL rexec_accept: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge CLK);
    bus.req1_valid = 0;
    #2 nRST = 0;
    #1;
    vectors++;
    if ({bus.rsp1_valid, bus.alu_porta} !== 33'h0) begin
      miscompares++;
      $display("FAIL rexec_abort: got valid=%b a=%h expected 0 0", bus.rsp1_valid, bus.alu_porta);
    end
    @(negedge CLK);
    nRST = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      vectors++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL rexec_no_rsp[%0d]: got %b expected 00", i, {bus.rsp0_valid, bus.rsp1_valid});
      end
    end
    bus.req0_valid = 1; bus.req0_op = 4'h3; bus.req0_a = 32'd9; bus.req0_b = 32'd4;
    bus.req1_valid = 1;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rexec_regrant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge CLK);
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(negedge CLK); #1;
    vectors++;
    if ({bus.rsp0_valid, bus.rsp0_data, bus.rsp0_flags} !== {1'b1, 32'd5, 3'b000}) begin
      miscompares++;
      $display("FAIL rexec_rsp0: got valid=%b data=%h flags=%b expected 1 00000005 000",
               bus.rsp0_valid, bus.rsp0_data, bus.rsp0_flags);
    end
    bus.rsp0_ready = 1;
    @(negedge CLK);
    bus.rsp0_ready = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    bus.req0_valid = 1; bus.req0_op = 4'h2; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    @(negedge CLK);
    bus.req0_valid = 0; bus.req1_valid = 1;
    @(negedge CLK);
    #2 nRST = 0;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_handshake: got %b expected 0000",
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    vectors++;
    if ({bus.alu_op, bus.alu_porta, bus.alu_portb} !== '0) begin
      miscompares++;
      $display("FAIL mid_alu: got op=%h a=%h b=%h expected zeros", bus.alu_op, bus.alu_porta, bus.alu_portb);
    end
`ifdef ALU_ARB_STATS_EN
    vectors++;
    if ({bus.stat_gnt0, bus.stat_gnt1, bus.stat_busy} !== '0) begin
      miscompares++;
      $display("FAIL mid_stats: got %h %h %h expected 0 0 0", bus.stat_gnt0, bus.stat_gnt1, bus.stat_busy);
    end
`endif
    @(negedge CLK);
    clear_inputs();
    nRST = 1;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    @(negedge CLK);
    nRST = 0; #1; nRST = 1;
    bus.rsp0_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus.req0_valid = 1; bus.req0_op = 4'h2; bus.req0_a = i; bus.req0_b = 32'd1;
      @(negedge CLK);
      bus.req0_valid = 0;
      @(negedge CLK);
    end
    @(negedge CLK); #1;
    vectors++;
    if ({bus.stat_gnt0, bus.stat_gnt1, bus.stat_busy} !== {2'd3, 2'd0, 2'd3}) begin
      miscompares++;
      $display("FAIL stats_sat: got gnt0=%0d gnt1=%0d busy=%0d expected 3 0 3",
               bus.stat_gnt0, bus.stat_gnt1, bus.stat_busy);
    end
    bus.rsp0_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_both();
    test_stall();
    test_reset_exec();
    test_reset_mid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
